wb_result_stage: RTL

- Parametrised writeback-result stage for the RISC-V core; the successor to the 2:1 ALU/memory result select.
- Selects among four result sources.
- Performs RV load sign/zero extension with byte-lane alignment.
- Registers the writeback bundle (result, rd, write enable, valid) with stall and flush control, giving a one-cycle pipelined writeback to the register file.

---
 rtl/wb_result_stage_if.sv | 33 +++
 rtl/wb_result_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/wb_result_stage_if.sv
// Writeback-stage bundle: upstream control/data into the stage and the
// registered writeback outputs toward the register file.
interface wb_result_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [1:0]      ResultSrc;
  logic [XLEN-1:0] ALUResult;
  logic [XLEN-1:0] ReadData;
  logic [XLEN-1:0] PCPlus4;
  logic [XLEN-1:0] ImmExt;
  logic [2:0]      LoadFunct3;
  logic            RegWrite;
  logic [4:0]      Rd;
  logic [XLEN-1:0] Result_W;
  logic [4:0]      Rd_W;
  logic            RegWrite_W;
  logic            valid_W;

  modport master (
    output in_valid, stall, flush, ResultSrc, ALUResult, ReadData, PCPlus4,
           ImmExt, LoadFunct3, RegWrite, Rd,
    input  Result_W, Rd_W, RegWrite_W, valid_W
  );

  modport slave (
    input  in_valid, stall, flush, ResultSrc, ALUResult, ReadData, PCPlus4,
           ImmExt, LoadFunct3, RegWrite, Rd,
    output Result_W, Rd_W, RegWrite_W, valid_W
  );
endinterface

// File: rtl/wb_result_stage.sv
// Writeback result stage: 4:1 result select, RV load byte-lane extraction and
// sign/zero extension, and the registered writeback bundle with stall/flush.
module wb_result_stage #(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input logic             clk,
  input logic             reset,
  wb_result_stage_if.slave wb
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_IMM  = 2'b11
  } src_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_RSV = 3'b111
  } ld_e;

  logic [OFFW-1:0] off;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] lw_ext;
  logic [XLEN-1:0] lwu_ext;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] result_sel;

  logic [XLEN-1:0] result_d, result_q;
  logic [4:0]      rd_d, rd_q;
  logic            regwrite_d, regwrite_q;
  logic            valid_d, valid_q;

  assign off = wb.ALUResult[OFFW-1:0];

  always_comb begin
    byte_lane = '0;
    for (int unsigned i = 0; i < XLEN / 8; i++) begin
      if (off == OFFW'(i)) byte_lane = wb.ReadData[8*i +: 8];
    end
  end

  // Halfword lane ignores off[0]: misaligned halves fall back to the lower lane.
  always_comb begin
    half_lane = '0;
    for (int unsigned i = 0; i < XLEN / 16; i++) begin
      if (off[OFFW-1:1] == (OFFW-1)'(i)) half_lane = wb.ReadData[16*i +: 16];
    end
  end

  generate
    if (XLEN == 64) begin : g_word64
      logic [31:0] word_lane;
      always_comb begin
        word_lane = off[OFFW-1] ? wb.ReadData[63:32] : wb.ReadData[31:0];
        lw_ext    = {{32{word_lane[31]}}, word_lane};
        lwu_ext   = {32'b0, word_lane};
      end
    end else begin : g_word32
      always_comb begin
        lw_ext  = wb.ReadData;
        lwu_ext = wb.ReadData;
      end
    end
  endgenerate

  always_comb begin
    load_ext = wb.ReadData;
    case (ld_e'(wb.LoadFunct3))
      F3_LB:   load_ext = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LH:   load_ext = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LW:   load_ext = lw_ext;
      F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, half_lane};
      F3_LWU:  load_ext = lwu_ext;
      F3_LD:   load_ext = wb.ReadData;
      default: load_ext = wb.ReadData;
    endcase
  end

  always_comb begin
    result_sel = wb.ALUResult;
    case (src_e'(wb.ResultSrc))
      SRC_ALU:  result_sel = wb.ALUResult;
      SRC_LOAD: result_sel = load_ext;
      SRC_PC4:  result_sel = wb.PCPlus4;
      SRC_IMM:  result_sel = wb.ImmExt;
      default:  result_sel = wb.ALUResult;
    endcase
  end

  // Stall is applied at the register so a flush under stall is simply dropped.
  always_comb begin
    result_d   = result_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    valid_d    = valid_q;
    if (wb.flush) begin
      result_d   = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      valid_d    = 1'b0;
    end else begin
      result_d   = result_sel;
      rd_d       = wb.Rd;
      regwrite_d = wb.in_valid & wb.RegWrite & (wb.Rd != 5'd0);
      valid_d    = wb.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!wb.stall) begin
      result_q   <= result_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
    end
  end

  assign wb.Result_W   = result_q;
  assign wb.Rd_W       = rd_q;
  assign wb.RegWrite_W = regwrite_q;
  assign wb.valid_W    = valid_q;

endmodule
